// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported memory between the CPU instruction and data ports.
// Each pipeline window serialises DM then IM, then releases the CPU for one cycle.
module mem_arbiter #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] im_addr,
  input  logic              im_en,
  output logic [DATA_W-1:0] im_rdata,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_en,
  input  logic              dm_write,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StArb, StDmAcc, StImAcc, StRelease} state_e;

  state_e          state;
  logic            need_im;
  logic [CntW-1:0] cnt;
  logic            acc_done;

  // A ready on the final allowed cycle wins over the timeout.
  assign acc_done = mem_ready || (cnt == CntMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StArb;
      need_im     <= 1'b0;
      cnt         <= '0;
      im_rdata    <= '0;
      dm_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        StArb: begin
          need_im <= im_en;
          cnt     <= '0;
          if (dm_en)      state <= StDmAcc;
          else if (im_en) state <= StImAcc;
          else            state <= StRelease;
        end
        StDmAcc: begin
          if (acc_done) begin
            if (!dm_write) dm_rdata <= mem_ready ? mem_rdata : ERR_DATA;
            if (!mem_ready) timeout_err <= 1'b1;
            cnt   <= '0;
            state <= need_im ? StImAcc : StRelease;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StImAcc: begin
          if (acc_done) begin
            im_rdata <= mem_ready ? mem_rdata : ERR_DATA;
            if (!mem_ready) timeout_err <= 1'b1;
            cnt   <= '0;
            state <= StRelease;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StRelease: state <= StArb;
      endcase
    end
  end

  // Memory-side signals depend only on the registered state, so async reset drops mem_en at once.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      StDmAcc: begin
        mem_en    = 1'b1;
        mem_we    = dm_write;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      StImAcc: begin
        mem_en   = 1'b1;
        mem_addr = im_addr;
      end
      default: ;
    endcase
  end

  assign stall = (state != StRelease);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model with programmable latency, access and result scoreboards.
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] im_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic        im_en = 1'b0, dm_en = 1'b0, dm_write = 1'b0, mem_ready = 1'b0;
  logic [31:0] im_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        stall, mem_en, mem_we, timeout_err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TIMEOUT),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .im_addr    (im_addr),
    .im_en      (im_en),
    .im_rdata   (im_rdata),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_en      (dm_en),
    .dm_write   (dm_write),
    .dm_rdata   (dm_rdata),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .timeout_err(timeout_err)
  );

  typedef struct packed {logic [31:0] addr; logic we; logic [31:0] wdata;} acc_t;
  typedef struct packed {logic [31:0] im; logic [31:0] dm; logic [31:0] cyc;} res_t;

  acc_t        obs_q[$], exp_acc_q[$];
  res_t        res_q[$], exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          delay = 0, wcnt = 0, unstable = 0, multi_low = 0, cyc = 0;
  logic        prev_wait = 1'b0, prev_low = 1'b0;
  logic [31:0] prev_addr = '0;
  int          passed = 0, total = 0;

  // Memory model plus release monitor; everything sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      cyc      = 0;
      prev_low = 1'b0;
    end else begin
      cyc++;
      if (!stall) begin
        if (prev_low) multi_low++;
        res_q.push_back('{im: im_rdata, dm: dm_rdata, cyc: cyc});
        cyc = 0;
      end
      prev_low = !stall;
    end
    if (rst || !mem_en) begin
      if (prev_wait && !rst) unstable++;
      mem_ready = 1'b0;
      mem_rdata = 32'h5555AAAA;
      wcnt      = 0;
      prev_wait = 1'b0;
    end else begin
      if (prev_wait && mem_addr !== prev_addr) unstable++;
      if (wcnt == delay) begin
        mem_ready = 1'b1;
        obs_q.push_back('{addr: mem_addr, we: mem_we, wdata: mem_wdata});
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          mem_rdata     = 32'h0BAD0BAD;
        end else begin
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : ~mem_addr;
        end
        wcnt = 0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'h5555AAAA;
        wcnt++;
      end
      prev_wait = !mem_ready;
      prev_addr = mem_addr;
    end
  end

  task automatic drive(input logic ie, input logic [31:0] ia, input logic de, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    im_en    = ie;
    im_addr  = ia;
    dm_en    = de;
    dm_write = dw;
    dm_addr  = da;
    dm_wdata = dd;
  endtask

  task automatic wait_release(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (res_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic bit acc_match();
    bit m = (obs_q.size() == exp_acc_q.size());
    for (int i = 0; i < obs_q.size() && m; i++) m = (obs_q[i] === exp_acc_q[i]);
    return m;
  endfunction

  task automatic test_reset;
    bit ok;
    #1 rst = 1'b1;
    #2;
    total++; if (stall !== 1'b1) $display("FAIL reset_stall: got %b want 1", stall); else passed++;
    total++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", mem_en); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else passed++;
    total++; if (im_rdata !== 32'h0) $display("FAIL reset_im_rdata: got %h want 0", im_rdata);
    else passed++;
    total++; if (dm_rdata !== 32'h0) $display("FAIL reset_dm_rdata: got %h want 0", dm_rdata);
    else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_release(ok);
    total++; if (!ok) $display("FAIL reset_idle_release: got no release want one"); else passed++;
    res_q.delete();
  endtask

  task automatic test_fetch;
    bit ok;
    res_t r, e;
    logic [31:0] addrs [2];
    logic [31:0] data [2];
    addrs[0] = 32'h40; data[0] = 32'h00000013;
    addrs[1] = 32'h44; data[1] = 32'h00100093;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, addrs[k], 1'b0, 1'b0, 32'h0, 32'h0);
      exp_q.push_back('{im: data[k], dm: 32'h0, cyc: 3});
      exp_acc_q.push_back('{addr: addrs[k], we: 1'b0, wdata: 32'h0});
      wait_release(ok);
      total++; if (!ok) $display("FAIL fetch_release: got none want release"); else passed++;
      if (ok) begin
        r = res_q.pop_front();
        e = exp_q.pop_front();
        total++;
        if (r !== e) $display("FAIL fetch_result: got im=%h dm=%h cyc=%0d want im=%h dm=%h cyc=%0d",
                              r.im, r.dm, r.cyc, e.im, e.dm, e.cyc);
        else passed++;
      end
      total++; if (!acc_match()) $display("FAIL fetch_access: got %0d accesses want %0d",
                                          obs_q.size(), exp_acc_q.size());
      else passed++;
      obs_q.delete();
      exp_acc_q.delete();
    end
    total++; if (multi_low !== 0) $display("FAIL fetch_stall_pulse: got %0d long lows want 0",
                                           multi_low);
    else passed++;
  endtask

  task automatic test_load_fetch;
    bit ok;
    res_t r, e;
    drive(1'b1, 32'h10000000, 1'b1, 1'b0, 32'h100, 32'h0);
    exp_q.push_back('{im: 32'h00A00093, dm: 32'hCAFEF00D, cyc: 4});
    exp_acc_q.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0});
    exp_acc_q.push_back('{addr: 32'h10000000, we: 1'b0, wdata: 32'h0});
    wait_release(ok);
    total++; if (!ok) $display("FAIL load_fetch_release: got none want release"); else passed++;
    if (ok) begin
      r = res_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (r !== e) $display("FAIL load_fetch_result: got im=%h dm=%h cyc=%0d want im=%h dm=%h cyc=%0d",
                            r.im, r.dm, r.cyc, e.im, e.dm, e.cyc);
      else passed++;
    end
    total++; if (!acc_match()) $display("FAIL load_fetch_order: got first addr %h want %h",
                                        obs_q[0].addr, exp_acc_q[0].addr);
    else passed++;
    obs_q.delete();
    exp_acc_q.delete();
  endtask

  task automatic test_store;
    bit ok;
    res_t r, e;
    drive(1'b1, 32'h40, 1'b1, 1'b1, 32'h200, 32'h12345678);
    exp_q.push_back('{im: 32'h00000013, dm: 32'hCAFEF00D, cyc: 4});
    exp_acc_q.push_back('{addr: 32'h200, we: 1'b1, wdata: 32'h12345678});
    exp_acc_q.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'h0});
    wait_release(ok);
    total++; if (!ok) $display("FAIL store_release: got none want release"); else passed++;
    if (ok) begin
      r = res_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (r !== e) $display("FAIL store_result: got im=%h dm=%h cyc=%0d want im=%h dm=%h cyc=%0d",
                            r.im, r.dm, r.cyc, e.im, e.dm, e.cyc);
      else passed++;
    end
    total++; if (!acc_match()) $display("FAIL store_access: got we=%b/%b want 1/0",
                                        obs_q[0].we, obs_q[1].we);
    else passed++;
    obs_q.delete();
    exp_acc_q.delete();
  endtask

  task automatic test_slow;
    bit ok;
    res_t r, e;
    int base = unstable;
    delay = 5;
    drive(1'b1, 32'h44, 1'b1, 1'b0, 32'h200, 32'h0);
    exp_q.push_back('{im: 32'h00100093, dm: 32'h12345678, cyc: 14});
    wait_release(ok);
    total++; if (!ok) $display("FAIL slow_release: got none want release"); else passed++;
    if (ok) begin
      r = res_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (r !== e) $display("FAIL slow_result: got im=%h dm=%h cyc=%0d want im=%h dm=%h cyc=%0d",
                            r.im, r.dm, r.cyc, e.im, e.dm, e.cyc);
      else passed++;
    end
    total++; if (unstable - base !== 0) $display("FAIL slow_stable: got %0d changes want 0",
                                                 unstable - base);
    else passed++;
    total++; if (multi_low !== 0) $display("FAIL slow_stall_pulse: got %0d long lows want 0",
                                           multi_low);
    else passed++;
    obs_q.delete();
  endtask

  task automatic test_ready_at_limit;
    bit ok;
    res_t r, e;
    delay = TIMEOUT - 1;
    drive(1'b1, 32'h10000000, 1'b1, 1'b0, 32'h100, 32'h0);
    exp_q.push_back('{im: 32'h00A00093, dm: 32'hCAFEF00D, cyc: 2 * TIMEOUT + 2});
    wait_release(ok);
    total++; if (!ok) $display("FAIL limit_release: got none want release"); else passed++;
    if (ok) begin
      r = res_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (r !== e) $display("FAIL limit_result: got im=%h dm=%h cyc=%0d want im=%h dm=%h cyc=%0d",
                            r.im, r.dm, r.cyc, e.im, e.dm, e.cyc);
      else passed++;
    end
    total++; if (timeout_err !== 1'b0) $display("FAIL limit_no_err: got %b want 0", timeout_err);
    else passed++;
    obs_q.delete();
  endtask

  task automatic test_timeout;
    bit ok;
    res_t r, e;
    delay = 1000;
    drive(1'b1, 32'h48, 1'b1, 1'b0, 32'h300, 32'h0);
    exp_q.push_back('{im: 32'hDEADBEEF, dm: 32'hDEADBEEF, cyc: 2 * TIMEOUT + 2});
    wait_release(ok);
    total++; if (!ok) $display("FAIL timeout_release: got none want release"); else passed++;
    if (ok) begin
      r = res_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (r !== e) $display("FAIL timeout_result: got im=%h dm=%h cyc=%0d want im=%h dm=%h cyc=%0d",
                            r.im, r.dm, r.cyc, e.im, e.dm, e.cyc);
      else passed++;
    end
    total++; if (timeout_err !== 1'b1) $display("FAIL timeout_err_set: got %b want 1", timeout_err);
    else passed++;
    total++; if (obs_q.size() !== 0) $display("FAIL timeout_no_handshake: got %0d want 0",
                                              obs_q.size());
    else passed++;
    delay = 0;
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back('{im: 32'h00000013, dm: 32'hDEADBEEF, cyc: 3});
    wait_release(ok);
    total++; if (!ok) $display("FAIL timeout_next_release: got none want release"); else passed++;
    if (ok) begin
      r = res_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (r !== e) $display("FAIL timeout_next_result: got im=%h dm=%h cyc=%0d want im=%h dm=%h cyc=%0d",
                            r.im, r.dm, r.cyc, e.im, e.dm, e.cyc);
      else passed++;
    end
    total++; if (timeout_err !== 1'b1) $display("FAIL timeout_err_sticky: got %b want 1", timeout_err);
    else passed++;
    obs_q.delete();
  endtask

  task automatic test_reset_mid;
    bit ok;
    res_t r, e;
    delay = 1000;
    drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0);
    repeat (4) @(negedge clk);
    #1;
    total++; if (mem_en !== 1'b1 || mem_addr !== 32'h100)
      $display("FAIL midreset_pre: got en=%b addr=%h want en=1 addr=00000100", mem_en, mem_addr);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if (mem_en !== 1'b0) $display("FAIL midreset_mem_en: got %b want 0", mem_en); else passed++;
    total++; if (stall !== 1'b1) $display("FAIL midreset_stall: got %b want 1", stall); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL midreset_err: got %b want 0", timeout_err);
    else passed++;
    @(negedge clk);
    #1 rst = 1'b0;
    delay = 0;
    res_q.delete();
    obs_q.delete();
    drive(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0);
    // The ARB cycle overlaps the reset-held falling edge, so only IM_ACC and RELEASE are counted.
    exp_q.push_back('{im: 32'h00100093, dm: 32'h0, cyc: 2});
    wait_release(ok);
    total++; if (!ok) $display("FAIL midreset_release: got none want release"); else passed++;
    if (ok) begin
      r = res_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (r !== e) $display("FAIL midreset_result: got im=%h dm=%h cyc=%0d want im=%h dm=%h cyc=%0d",
                            r.im, r.dm, r.cyc, e.im, e.dm, e.cyc);
      else passed++;
    end
  endtask

  initial begin
    mem[32'h40]       = 32'h00000013;
    mem[32'h44]       = 32'h00100093;
    mem[32'h100]      = 32'hCAFEF00D;
    mem[32'h10000000] = 32'h00A00093;
    test_reset();
    test_fetch();
    test_load_fetch();
    test_store();
    test_slow();
    test_ready_at_limit();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1);
  end

endmodule
